// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared constants for the seven-segment display path: digit codes understood
// by the digit decoder, the BCD scratch width, and the formatter FSM states.
// Ports: none (package).
// -----------------------------------------------------------------------------
package display_pkg;

  localparam int DIG_W = 5;
  localparam int BCD_W = 16;

  // Codes 0..9 are plain decimal digits; these two are the only non-numeric
  // codes the decoder knows about.
  localparam logic [DIG_W-1:0] DIG_BLANK = 5'b10000;
  localparam logic [DIG_W-1:0] DIG_MINUS = 5'b10001;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    FORMAT = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Double-dabble nibble correction: any BCD nibble of 5 or more gets 3 added so
// that the following left shift carries correctly into the next decade.
// Ports:
//   i_nib  4-bit BCD nibble before correction
//   o_nib  4-bit corrected nibble
// -----------------------------------------------------------------------------
module bcd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/display_value_formatter.sv
// -----------------------------------------------------------------------------
// display_value_formatter
// Converts a signed two's-complement value into four 5-bit digit codes for the
// seven-segment scanner. Sequential shift-and-add-3 binary-to-BCD, then
// leading-zero blanking, sign placement and overflow ("----") formatting.
// Digit outputs only change on the edge that raises done.
// Ports:
//   clock     system clock, rising edge
//   reset_n   asynchronous active-low reset
//   start     conversion request, sampled only in IDLE
//   value_in  signed input value, captured when start is accepted
//   busy      high from the accepting edge until done falls
//   done      one-cycle pulse, digits valid from the same edge
//   overflow  last conversion was outside the displayable range
//   digit3..0 digit codes, digit3 leftmost
// -----------------------------------------------------------------------------
module display_value_formatter
  import display_pkg::*;
#(
  parameter int WIDTH    = 14,
  parameter int BLANK_LZ = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] value_in,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [DIG_W-1:0] digit3,
  output logic [DIG_W-1:0] digit2,
  output logic [DIG_W-1:0] digit1,
  output logic [DIG_W-1:0] digit0
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_value;
  logic [WIDTH-1:0]   r_mag;
  logic               r_neg;
  logic               r_ovf;
  logic               r_carry;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   w_mag;
  logic [31:0]        w_mag_ext;
  logic               w_ovf;
  logic [BCD_W-1:0]   w_corr;
  logic [3:0]         w_n3, w_n2, w_n1, w_n0;
  logic               w_b3, w_b2, w_b1;
  logic               w_fmt_ovf;
  logic [DIG_W-1:0]   w_d3, w_d2, w_d1, w_d0;

  // NOTE: the magnitude is kept as a WIDTH-bit unsigned value, so negating the
  // most negative input (e.g. -8192 -> 8192) fits without wrapping.
  assign w_mag     = r_value[WIDTH-1] ? (~r_value + WIDTH'(1)) : r_value;
  assign w_mag_ext = 32'(w_mag);
  assign w_ovf     = r_value[WIDTH-1] ? (w_mag_ext > 32'd999) : (w_mag_ext > 32'd9999);

  // Add-3 correction on every decade before each shift.
  for (genvar g = 0; g < BCD_W / 4; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nib (r_bcd[4*g +: 4]),
      .o_nib (w_corr[4*g +: 4])
    );
  end

  assign w_n3 = r_bcd[15:12];
  assign w_n2 = r_bcd[11:8];
  assign w_n1 = r_bcd[7:4];
  assign w_n0 = r_bcd[3:0];

  // A carry out of the thousands decade means a fifth digit, which can only
  // happen for values already flagged out of range.
  assign w_fmt_ovf = r_ovf | r_carry;

  // NOTE: every signal written here gets a value on every path before any
  // conditional override, so no latch can be inferred.
  always_comb begin
    w_b3 = (BLANK_LZ != 0) && (w_n3 == 4'd0);
    w_b2 = w_b3 && (w_n2 == 4'd0);
    w_b1 = w_b2 && (w_n1 == 4'd0);
    w_d3 = w_b3 ? DIG_BLANK : {1'b0, w_n3};
    w_d2 = w_b2 ? DIG_BLANK : {1'b0, w_n2};
    w_d1 = w_b1 ? DIG_BLANK : {1'b0, w_n1};
    w_d0 = {1'b0, w_n0};
    // Minus sits in the blanked slot right next to the leading digit; without
    // blanking nothing is blanked and it lands in digit3 (magnitude <= 999).
    if (r_neg) begin
      if (w_b1)      w_d1 = DIG_MINUS;
      else if (w_b2) w_d2 = DIG_MINUS;
      else           w_d3 = DIG_MINUS;
    end
    if (w_fmt_ovf) begin
      w_d3 = DIG_MINUS;
      w_d2 = DIG_MINUS;
      w_d1 = DIG_MINUS;
      w_d0 = DIG_MINUS;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      digit3   <= DIG_BLANK;
      digit2   <= DIG_BLANK;
      digit1   <= DIG_BLANK;
      digit0   <= 5'd0;
      r_value  <= '0;
      r_mag    <= '0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
      r_carry  <= 1'b0;
      r_bcd    <= '0;
      r_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_value <= value_in;
            busy    <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_neg   <= r_value[WIDTH-1];
          r_mag   <= w_mag;
          r_ovf   <= w_ovf;
          r_carry <= 1'b0;
          r_bcd   <= '0;
          r_cnt   <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          // Runs the full WIDTH shifts even on overflow for constant latency.
          r_bcd   <= {w_corr[BCD_W-2:0], r_mag[WIDTH-1]};
          r_carry <= r_carry | w_corr[BCD_W-1];
          r_mag   <= r_mag << 1;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= FORMAT;
        end
        FORMAT: begin
          digit3   <= w_d3;
          digit2   <= w_d2;
          digit1   <= w_d1;
          digit0   <= w_d0;
          overflow <= w_fmt_ovf;
          done     <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_value_formatter.sv
// -----------------------------------------------------------------------------
// tb_display_value_formatter
// Two formatter instances (leading-zero blanking on and off) share stimulus.
// Expected results come from an arithmetic decimal model and are queued when a
// start is issued; one monitor per instance pops and compares on each done.
// -----------------------------------------------------------------------------
module tb_display_value_formatter;
  import display_pkg::*;

  localparam int WIDTH = 14;

  typedef struct {
    logic [3:0][DIG_W-1:0] dig;
    logic                  ovf;
    int                    due;
    int                    val;
  } exp_t;

  logic             clock;
  logic             reset_n;
  logic             start;
  logic [WIDTH-1:0] value_in;

  logic             busy_a, done_a, ovf_a;
  logic [DIG_W-1:0] d3_a, d2_a, d1_a, d0_a;
  logic             busy_z, done_z, ovf_z;
  logic [DIG_W-1:0] d3_z, d2_z, d1_z, d0_z;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   n_done_a = 0;
  exp_t q_a[$];
  exp_t q_z[$];
  exp_t e_a, e_z;

  display_value_formatter #(.WIDTH(WIDTH), .BLANK_LZ(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start), .value_in(value_in),
    .busy(busy_a), .done(done_a), .overflow(ovf_a),
    .digit3(d3_a), .digit2(d2_a), .digit1(d1_a), .digit0(d0_a)
  );

  display_value_formatter #(.WIDTH(WIDTH), .BLANK_LZ(0)) dut_z (
    .clock(clock), .reset_n(reset_n), .start(start), .value_in(value_in),
    .busy(busy_z), .done(done_z), .overflow(ovf_z),
    .digit3(d3_z), .digit2(d2_z), .digit1(d1_z), .digit0(d0_z)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic int sext(input int raw);
    logic signed [WIDTH-1:0] t;
    t = WIDTH'(raw);
    return int'(t);
  endfunction

  // Decimal reference: digits by division, blanking by count of significant
  // digits, sign placed just left of the leading digit.
  function automatic exp_t model(input int raw, input bit blz, input int due);
    exp_t e;
    int   v, mag, nsig, p;
    bit   neg;
    v     = sext(raw);
    neg   = (v < 0);
    mag   = neg ? -v : v;
    e.val = v;
    e.due = due;
    e.ovf = neg ? (mag > 999) : (mag > 9999);
    nsig  = (mag >= 1000) ? 4 : (mag >= 100) ? 3 : (mag >= 10) ? 2 : 1;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      e.dig[i] = 5'((mag / p) % 10);
      if (blz && i >= nsig) e.dig[i] = DIG_BLANK;
      p = p * 10;
    end
    if (neg && !e.ovf) e.dig[blz ? nsig : 3] = DIG_MINUS;
    if (e.ovf) for (int i = 0; i < 4; i++) e.dig[i] = DIG_MINUS;
    return e;
  endfunction

  task automatic push_both(input int raw, input int due);
    q_a.push_back(model(raw, 1'b1, due));
    q_z.push_back(model(raw, 1'b0, due));
  endtask

  always @(negedge clock) begin
    if (done_a) begin
      n_done_a++;
      if (q_a.size() == 0) check("unexpected_done_a", 32'd1, 32'd0);
      else begin
        e_a = q_a.pop_front();
        check($sformatf("digits_a(%0d)", e_a.val), 32'({d3_a, d2_a, d1_a, d0_a}), 32'(e_a.dig));
        check($sformatf("ovf_a(%0d)", e_a.val), 32'(ovf_a), 32'(e_a.ovf));
        check($sformatf("latency_a(%0d)", e_a.val), cyc, e_a.due);
        check($sformatf("busy_in_done_a(%0d)", e_a.val), 32'(busy_a), 32'd1);
      end
    end
  end

  always @(negedge clock) begin
    if (done_z) begin
      if (q_z.size() == 0) check("unexpected_done_z", 32'd1, 32'd0);
      else begin
        e_z = q_z.pop_front();
        check($sformatf("digits_z(%0d)", e_z.val), 32'({d3_z, d2_z, d1_z, d0_z}), 32'(e_z.dig));
        check($sformatf("ovf_z(%0d)", e_z.val), 32'(ovf_z), 32'(e_z.ovf));
        check($sformatf("latency_z(%0d)", e_z.val), cyc, e_z.due);
      end
    end
  end

  // Called at a falling edge while idle; returns at the falling edge of the
  // first idle cycle after the conversion.
  task automatic convert(input int raw);
    int busy_cnt;
    value_in = WIDTH'(raw);
    start    = 1'b1;
    push_both(raw, cyc + WIDTH + 3);
    @(negedge clock);
    start    = 1'b0;
    value_in = WIDTH'($urandom);
    busy_cnt = 0;
    for (int i = 0; i < 40 && busy_a; i++) begin
      busy_cnt++;
      @(negedge clock);
    end
    check($sformatf("busy_len(%0d)", sext(raw)), busy_cnt, WIDTH + 3);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy_a), 32'd0);
    check({tag, "_done"}, 32'(done_a), 32'd0);
    check({tag, "_ovf"}, 32'(ovf_a), 32'd0);
    check({tag, "_digits_a"}, 32'({d3_a, d2_a, d1_a, d0_a}),
          32'({DIG_BLANK, DIG_BLANK, DIG_BLANK, 5'd0}));
    check({tag, "_digits_z"}, 32'({d3_z, d2_z, d1_z, d0_z}),
          32'({DIG_BLANK, DIG_BLANK, DIG_BLANK, 5'd0}));
  endtask

  initial begin
    int n_before;
    int fixed_vals[13] = '{1234, 0, -45, -999, 9999, 10000, -1000, -8192,
                           8191, 7, -7, -1, 100};
    reset_n  = 1'b0;
    start    = 1'b0;
    value_in = '0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clock);

    foreach (fixed_vals[i]) convert(fixed_vals[i]);

    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) convert(int'($urandom_range(0, 16383)) - 8192);
      else            convert(int'($urandom_range(0, 2400)) - 1200);
    end

    // Start pulses while busy and during DONE are ignored.
    value_in = WIDTH'(1234);
    start    = 1'b1;
    push_both(1234, cyc + WIDTH + 3);
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    value_in = WIDTH'(77);
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    value_in = '0;
    for (int i = 0; i < 40 && !done_a; i++) @(negedge clock);
    check("ovl_done_seen", 32'(done_a), 32'd1);
    value_in = WIDTH'(77);
    start    = 1'b1;
    @(negedge clock);
    check("ovl_idle_after_done", 32'(busy_a), 32'd0);
    push_both(77, cyc + WIDTH + 3);
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 40 && busy_a; i++) @(negedge clock);
    check("ovl_second_finished", 32'(busy_a), 32'd0);

    // Reset in the middle of a conversion discards it.
    convert(42);
    value_in = WIDTH'(5678);
    start    = 1'b1;
    push_both(5678, cyc + WIDTH + 3);
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    reset_n = 1'b0;
    q_a.delete();
    q_z.delete();
    #1;
    check_reset_outputs("midreset");
    n_before = n_done_a;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (25) @(negedge clock);
    check("no_done_after_reset", n_done_a, n_before);
    check_reset_outputs("after_release");

    convert(-5);
    repeat (2) @(negedge clock);
    check("queue_a_drained", q_a.size(), 0);
    check("queue_z_drained", q_z.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
